// File: rtl/ahfp_add_seq.sv
// ahfp_add_seq: multi-cycle IEEE-754 single-precision adder (align/add/normalise/pack).
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset
//   clk_en   - global enable; when low every register holds
//   start    - one-cycle request, operands sampled on the same edge
//   dataa    - operand A (IEEE-754 single)
//   datab    - operand B (IEEE-754 single)
//   result   - dataa + datab, held from done until the next accepted start
//   done     - one-cycle pulse, result valid in that cycle
//   busy     - high from accepted start through the done cycle
// Rounding is toward zero; denormal inputs are flushed to zero.
module ahfp_add_seq #(
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    localparam int unsigned SIG_W = 24;
    localparam int unsigned WW    = SIG_W + GUARD_BITS;
    localparam int unsigned LZ_W  = $clog2(WW + 1);
    localparam int unsigned EXP_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_PACK
    } state_t;

    state_t                    r_state;
    logic [31:0]               r_a;
    logic [31:0]               r_b;
    logic                      r_sign;
    logic                      r_eff_sub;
    logic [7:0]                r_ex;
    logic [WW-1:0]             r_mx;
    logic [WW-1:0]             r_my;
    logic [WW:0]               r_sum;
    logic signed [EXP_W-1:0]   r_exp;
    logic [22:0]               r_frac;
    logic                      r_zero;
    logic [31:0]               r_result;
    logic                      r_done;

    // Operand fields; exponent 0 flushes the significand to zero.
    logic [7:0]  w_ea, w_eb;
    logic [23:0] w_sig_a, w_sig_b;
    logic        w_a_ge_b;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_sig_a  = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_sig_b  = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
    assign w_a_ge_b = {w_ea, w_sig_a} >= {w_eb, w_sig_b};
    assign w_a_nan  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);

    // Alignment: X is the larger magnitude, Y is shifted right by the exponent gap.
    logic          w_sx, w_sy;
    logic [7:0]    w_ex, w_ey, w_shift;
    logic [23:0]   w_sig_x, w_sig_y;
    logic [WW-1:0] w_my_ext, w_my_al;

    assign w_sx     = w_a_ge_b ? r_a[31] : r_b[31];
    assign w_sy     = w_a_ge_b ? r_b[31] : r_a[31];
    assign w_ex     = w_a_ge_b ? w_ea : w_eb;
    assign w_ey     = w_a_ge_b ? w_eb : w_ea;
    assign w_sig_x  = w_a_ge_b ? w_sig_a : w_sig_b;
    assign w_sig_y  = w_a_ge_b ? w_sig_b : w_sig_a;
    assign w_shift  = w_ex - w_ey;
    assign w_my_ext = WW'(w_sig_y) << GUARD_BITS;
    assign w_my_al  = (w_shift >= 8'(WW)) ? '0 : (w_my_ext >> w_shift);

    // Leading-zero count of the non-carry part of the sum (WW when all zero).
    logic [LZ_W-1:0] w_lz;
    always_comb begin
        w_lz = LZ_W'(WW);
        for (int i = 0; i < int'(WW); i++) begin
            if (r_sum[i]) w_lz = LZ_W'(int'(WW) - 1 - i);
        end
    end

    // Normalisation: one right shift on carry, otherwise barrel left shift.
    logic [WW-1:0]           w_norm_mant;
    logic signed [EXP_W-1:0] w_ex_s;
    logic signed [EXP_W-1:0] w_norm_exp;
    logic                    w_unused;

    assign w_ex_s      = $signed(EXP_W'(r_ex));
    assign w_norm_mant = r_sum[WW] ? r_sum[WW:1] : (r_sum[WW-1:0] << w_lz);
    assign w_norm_exp  = r_sum[WW] ? (w_ex_s + 10'sd1)
                                   : (w_ex_s - $signed(EXP_W'(w_lz)));
    // Hidden bit and guard bits are dropped at pack (truncation).
    assign w_unused    = ^w_norm_mant;

    // Pack with special cases, highest priority last in the chain below first.
    logic [31:0] w_pack;
    always_comb begin
        w_pack = {r_sign, r_exp[7:0], r_frac};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[31] != r_b[31]))) begin
            w_pack = 32'h7FC0_0000;
        end else if (w_a_inf) begin
            w_pack = {r_a[31], 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_pack = {r_b[31], 8'hFF, 23'd0};
        end else if (r_zero) begin
            // Cancellation gives +0; only -0 + -0 keeps the negative sign.
            w_pack = r_eff_sub ? 32'h0000_0000 : {r_sign, 31'd0};
        end else if (r_exp >= 10'sd255) begin
            w_pack = {r_sign, 8'hFF, 23'd0};
        end else if (r_exp <= 10'sd0) begin
            w_pack = {r_sign, 31'd0};
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_ex      <= '0;
            r_mx      <= '0;
            r_my      <= '0;
            r_sum     <= '0;
            r_exp     <= '0;
            r_frac    <= '0;
            r_zero    <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else if (clk_en) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The done cycle still belongs to the previous operation.
                    if (start && !r_done) begin
                        r_a     <= dataa;
                        r_b     <= datab;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_sign    <= w_sx;
                    r_eff_sub <= w_sx ^ w_sy;
                    r_ex      <= w_ex;
                    r_mx      <= WW'(w_sig_x) << GUARD_BITS;
                    r_my      <= w_my_al;
                    r_state   <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= r_eff_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                                         : ({1'b0, r_mx} + {1'b0, r_my});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_frac  <= w_norm_mant[WW-2 -: 23];
                    r_exp   <= w_norm_exp;
                    r_zero  <= (r_sum == '0);
                    r_state <= S_PACK;
                end
                S_PACK: begin
                    r_result <= w_pack;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE) || r_done;

endmodule

// File: tb/tb_ahfp_add_seq.sv
// tb_ahfp_add_seq: directed self-checking bench for ahfp_add_seq.
module tb_ahfp_add_seq;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ahfp_add_seq #(.GUARD_BITS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; sampling/driving happens 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; counts edges and cycles where busy was low.
    task automatic wait_done(output int edges, output int busy_low);
        edges    = 0;
        busy_low = 0;
        while (!done && edges < 40) begin
            if (!busy) busy_low++;
            tick();
            edges++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) n++;
            tick();
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int edges, busy_low;
        start_op(a, b);
        wait_done(edges, busy_low);
        check({tag, " latency"}, 32'(edges + 1), 32'd5);
        check({tag, " busy_low"}, 32'(busy_low), 32'd0);
        check({tag, " busy@done"}, 32'(busy), 32'd1);
        check({tag, " result"}, result, exp);
        tick();
        check({tag, " done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int edges, busy_low, nd;
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        repeat (3) tick();
        check("reset result", result, 32'h0000_0000);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        run_vec("1+1",          32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        run_vec("1.5-1",        32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000);
        run_vec("1-1 cancel",   32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        run_vec("max+max",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        run_vec("inf-inf",      32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        run_vec("denorm+1",     32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
        run_vec("1+2^-30",      32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000);
        run_vec("trunc",        32'h3F80_0001, 32'hB380_0000, 32'h3F80_0000);
        run_vec("2+1",          32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
        run_vec("1-1.5 swap",   32'h3F80_0000, 32'hBFC0_0000, 32'hBF00_0000);
        run_vec("nan+1",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        run_vec("-inf+5",       32'hFF80_0000, 32'h40A0_0000, 32'hFF80_0000);
        run_vec("-0+-0",        32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run_vec("+0+-0",        32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        run_vec("minn+minn",    32'h0080_0000, 32'h0080_0000, 32'h0100_0000);
        run_vec("underflow",    32'h0080_0000, 32'h8080_0001, 32'h8000_0000);

        // Second start while busy is ignored; start in the done cycle is ignored too.
        start_op(32'h3F80_0000, 32'h3F80_0000);
        tick();
        start_op(32'h3FC0_0000, 32'hBF80_0000);
        wait_done(edges, busy_low);
        check("busy-start latency", 32'(edges + 3), 32'd5);
        check("busy-start result", result, 32'h4000_0000);
        start_op(32'h3FC0_0000, 32'hBF80_0000);
        check("done-cycle start busy", 32'(busy), 32'd0);
        count_dones(10, nd);
        check("busy-start extra done", 32'(nd), 32'd0);
        check("busy-start result held", result, 32'h4000_0000);

        // Three stalled cycles stretch latency from 5 to 8.
        start_op(32'h4000_0000, 32'h3F80_0000);
        tick();
        clk_en = 1'b0;
        repeat (3) tick();
        clk_en = 1'b1;
        wait_done(edges, busy_low);
        check("stall latency", 32'(edges + 5), 32'd8);
        check("stall result", result, 32'h4040_0000);
        clk_en = 1'b0;
        tick();
        check("stall done held", 32'(done), 32'd1);
        check("stall result held", result, 32'h4040_0000);
        clk_en = 1'b1;
        tick();
        check("stall done drop", 32'(done), 32'd0);

        // Reset while in ADD aborts the operation.
        start_op(32'h3FC0_0000, 32'hBF80_0000);
        tick();
        reset_n = 1'b0;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", result, 32'h0000_0000);
        reset_n = 1'b1;
        count_dones(10, nd);
        check("abort no done", 32'(nd), 32'd0);
        run_vec("post-abort", 32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
